// File: rtl/spike_event_scheduler_pkg.sv
// Shared definitions for the spike event scheduler: FSM state encoding and
// default parameter constants.
package spike_event_scheduler_pkg;

  localparam int DEF_NUM_NEURONS      = 4;
  localparam int DEF_IDX_WIDTH        = 2;
  localparam int DEF_REFRACTORY_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DONE     = 2'd2
  } sched_state_e;

endpackage

// File: rtl/spike_event_scheduler_rr_priority_picker.sv
// Combinational round-robin search: returns the first set pending bit at or
// after i_ptr, wrapping modulo NUM_NEURONS.
module rr_priority_picker
  import spike_event_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
  input  logic [NUM_NEURONS-1:0] i_pending,
  input  logic [IDX_WIDTH-1:0]   i_ptr,
  output logic                   o_found,
  output logic [IDX_WIDTH-1:0]   o_idx
);

  function automatic logic [IDX_WIDTH-1:0] rot_idx(input logic [IDX_WIDTH-1:0] p,
                                                   input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_NEURONS) s = s - NUM_NEURONS;
    return IDX_WIDTH'(s);
  endfunction

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    o_found = |i_pending;
    o_idx   = '0;
    for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
      if (i_pending[rot_idx(i_ptr, k)]) o_idx = rot_idx(i_ptr, k);
    end
  end

endmodule

// File: rtl/spike_event_scheduler.sv
// Per-timestep spike event scheduler: latches a layer spike vector and offers
// one neuron index per cycle, round-robin. Optional refractory masking is
// built when SPIKE_SCHED_REFRACTORY_EN is defined.
module spike_event_scheduler
  import spike_event_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS      = DEF_NUM_NEURONS,
  parameter int IDX_WIDTH        = DEF_IDX_WIDTH,
  parameter int REFRACTORY_WIDTH = DEF_REFRACTORY_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_step_start,
  input  logic [NUM_NEURONS-1:0]      i_spike_vec,
  input  logic [REFRACTORY_WIDTH-1:0] i_refractory_period,
  output logic                        o_out_valid,
  output logic [IDX_WIDTH-1:0]        o_out_idx,
  input  logic                        i_out_ready,
  output logic                        o_step_done,
  output logic                        o_busy,
  output logic                        o_overrun
);

  sched_state_e               r_state;
  logic [NUM_NEURONS-1:0]     r_pending;
  logic [IDX_WIDTH-1:0]       r_rr_ptr;
  logic                       r_out_valid;
  logic [IDX_WIDTH-1:0]       r_out_idx;
  logic                       r_step_done;
  logic                       r_busy;
  logic                       r_overrun;

  logic [NUM_NEURONS-1:0]     w_mask;
  logic [NUM_NEURONS-1:0]     w_load;
  logic [NUM_NEURONS-1:0]     w_pend_nxt;
  logic [IDX_WIDTH-1:0]       w_ptr_nxt;
  logic [IDX_WIDTH-1:0]       w_ptr_inc;
  logic [IDX_WIDTH-1:0]       w_pick_idx;
  logic                       w_pick_found;
  logic                       w_hs;
  logic                       w_start_ok;

  assign w_hs       = r_out_valid & i_out_ready;
  assign w_start_ok = (r_state == IDLE) & i_step_start;
  assign w_load     = i_spike_vec & ~w_mask;
  assign w_ptr_inc  = (r_out_idx == IDX_WIDTH'(NUM_NEURONS - 1)) ? '0
                                                                 : r_out_idx + IDX_WIDTH'(1);

  // Next pending/pointer values feed the picker so out_idx can be registered.
  always_comb begin
    w_pend_nxt = r_pending;
    w_ptr_nxt  = r_rr_ptr;
    if (w_start_ok) begin
      w_pend_nxt = w_load;
    end else if (w_hs) begin
      w_pend_nxt[r_out_idx] = 1'b0;
      w_ptr_nxt             = w_ptr_inc;
    end
  end

  rr_priority_picker #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_picker (
    .i_pending (w_pend_nxt),
    .i_ptr     (w_ptr_nxt),
    .o_found   (w_pick_found),
    .o_idx     (w_pick_idx)
  );

`ifdef SPIKE_SCHED_REFRACTORY_EN
  logic [NUM_NEURONS-1:0][REFRACTORY_WIDTH-1:0] r_refr_cnt;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_mask[i] = (r_refr_cnt[i] != '0);
  end

  // Decrement happens on the accepted start after the mask was applied; a
  // handshake never coincides with an accepted start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_refr_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_start_ok && (r_refr_cnt[i] != '0))
          r_refr_cnt[i] <= r_refr_cnt[i] - REFRACTORY_WIDTH'(1);
        else if (w_hs && (r_out_idx == IDX_WIDTH'(i)))
          r_refr_cnt[i] <= i_refractory_period;
      end
    end
  end
`else
  logic w_unused_refr;
  assign w_unused_refr = ^i_refractory_period;
  assign w_mask        = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_step_done <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      r_overrun   <= 1'b0;
      r_pending   <= w_pend_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      case (r_state)
        IDLE: begin
          if (i_step_start) begin
            r_busy <= 1'b1;
            if (w_pick_found) begin
              r_state     <= DISPATCH;
              r_out_valid <= 1'b1;
              r_out_idx   <= w_pick_idx;
            end else begin
              r_state     <= DONE;
              r_step_done <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          r_overrun <= i_step_start;
          if (w_hs) begin
            if (w_pick_found) begin
              r_out_idx <= w_pick_idx;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b0;
              r_step_done <= 1'b1;
            end
          end
        end
        DONE: begin
          r_overrun <= i_step_start;
          r_state   <= IDLE;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_idx   = r_out_idx;
  assign o_step_done = r_step_done;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

endmodule

// File: doc/spike_event_scheduler.md
SPIKE_EVENT_SCHEDULER -- requirements
Module: spike_event_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 4, giving the number of source neurons arbitrated.
REQ-002 The block SHALL have parameter IDX_WIDTH, default 2, giving the width of a neuron index; it SHALL satisfy 2**IDX_WIDTH >= NUM_NEURONS.
REQ-003 The block SHALL have parameter REFRACTORY_WIDTH, default 8, giving the width of the refractory period and of the per-neuron counters.
REQ-004 clk  input  1  system clock; single clock domain, all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 step_start  input  1  one-cycle pulse that begins a timestep.
REQ-007 spike_vec  input  NUM_NEURONS  layer spike vector, sampled only on an accepted step_start.
REQ-008 refractory_period  input  REFRACTORY_WIDTH  timesteps a neuron stays masked after dispatch.
REQ-009 out_valid  output  1  a spike event is offered to the shared synapse/accumulator datapath.
REQ-010 out_idx  output  IDX_WIDTH  index of the offered neuron.
REQ-011 out_ready  input  1  the datapath accepts the event when out_valid and out_ready are both 1.
REQ-012 step_done  output  1  one-cycle pulse: all events of the timestep have been dispatched.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 overrun  output  1  one-cycle pulse: step_start was rejected because the block was busy.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DISPATCH and DONE.
REQ-016 In IDLE, step_start SHALL load pending <= spike_vec & ~mask, where mask[i] = (refr_cnt[i] != 0).
REQ-017 From IDLE on step_start, the FSM SHALL go to DONE if the loaded pending is zero, otherwise to DISPATCH.
REQ-018 On an accepted step_start, every nonzero refr_cnt SHALL decrement by 1 after the mask has been evaluated.
REQ-019 In DISPATCH, out_valid SHALL equal 1 and out_idx SHALL be the first set pending bit at or after rr_ptr, searching round-robin modulo NUM_NEURONS.
REQ-020 out_idx SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 On a handshake, the block SHALL clear pending[out_idx], set rr_ptr <= (out_idx+1) mod NUM_NEURONS, and load refr_cnt[out_idx] <= refractory_period.
REQ-022 Sustained out_ready=1 SHALL give one event per cycle, i.e. N pending bits take N cycles.
REQ-023 The handshake that clears the last pending bit SHALL move the FSM to DONE.
REQ-024 DONE SHALL assert step_done for exactly one cycle and return to IDLE on the next edge.
REQ-025 Latency SHALL be: step_start edge to first out_valid = 1 cycle; last handshake to step_done = 1 cycle.
REQ-026 A step_start arriving in DISPATCH or DONE SHALL be ignored, with spike_vec not sampled and counters not decremented, and overrun SHALL pulse for one cycle.
REQ-027 out_valid SHALL be 0 in IDLE and in DONE.
REQ-028 A refractory_period of 0 SHALL never mask the neuron.

Reset
REQ-029 Reset SHALL force state=IDLE, pending=0, rr_ptr=0, all refr_cnt=0, out_valid=0, out_idx=0, step_done=0, busy=0 and overrun=0.
REQ-030 Reset asserted mid-DISPATCH SHALL abort the timestep with no step_done pulse; reset SHALL have priority over step_start and over any handshake in the same cycle.

Configuration
REQ-031 Macro SPIKE_SCHED_REFRACTORY_EN SHALL control refractory masking.
REQ-032 With SPIKE_SCHED_REFRACTORY_EN defined, the refractory counters and masking SHALL behave as in REQ-016/018/021.
REQ-033 Without SPIKE_SCHED_REFRACTORY_EN, no counters SHALL be built, mask SHALL be 0, and the refractory_period port SHALL remain present but be unused.

Structure
REQ-034 A shared package SHALL hold the state enumeration (IDLE, DISPATCH, DONE) and the default parameter constants.
REQ-035 One sub-module, rr_priority_picker, SHALL implement the combinational round-robin search over pending and rr_ptr.

Verification
REQ-036 spike_vec=4'b1011, out_ready=1, rr_ptr=0 -> out_idx sequence 0,1,3 on consecutive cycles, then step_done 1 cycle after the last handshake.
REQ-037 spike_vec=4'b0110 with out_ready low for 3 cycles -> out_idx holds at 1, out_valid stays 1, no bit is lost.
REQ-038 step_start while in DISPATCH -> overrun pulses once, pending is unchanged, and the event order is unaffected.
REQ-039 refractory_period=2, neuron 0 spiking every step -> dispatched at steps 0 and 3, masked at steps 1 and 2; without the macro it is dispatched every step.
REQ-040 spike_vec=0 -> DONE on the next edge, step_done pulse, out_valid never asserted.
REQ-041 reset asserted during DISPATCH with 2 events pending -> next cycle all outputs at reset values and no step_done pulse.
